// File: rtl/fb_access_arbiter.sv
// Frame buffer arbiter: VGA scanout (high priority) vs PRU pixel port (low priority, streak-bounded).
// Latency: grant combinational; RAM command registered at t+1; read data/valid at t+2.
// Backpressure: a requester holds its fields until granted; PRU waits at most MAX_SCAN_STREAK scan grants.
module fb_access_arbiter #(
    parameter int ADDR_W          = 19,
    parameter int DATA_W          = 2,
    parameter int PIX_COUNT       = 307200,
    parameter int MAX_SCAN_STREAK = 8
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_scan_req,
    input  logic [ADDR_W-1:0] i_scan_addr,
    output logic              o_scan_gnt,
    output logic [DATA_W-1:0] o_scan_rdata,
    output logic              o_scan_rvalid,
    input  logic              i_pru_req,
    input  logic              i_pru_we,
    input  logic [ADDR_W-1:0] i_pru_addr,
    input  logic [DATA_W-1:0] i_pru_wdata,
    output logic              o_pru_gnt,
    output logic [DATA_W-1:0] o_pru_rdata,
    output logic              o_pru_rvalid,
    output logic              o_mem_en,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_wdata,
    input  logic [DATA_W-1:0] i_mem_rdata,
    output logic              o_err_oob
);

    localparam int                CNT_W         = $clog2(MAX_SCAN_STREAK + 1);
    localparam logic [ADDR_W-1:0] LP_PIX_LIMIT  = ADDR_W'(PIX_COUNT);
    localparam logic [CNT_W-1:0]  LP_STREAK_MAX = CNT_W'(MAX_SCAN_STREAK);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_PRU  = 2'd2
    } state_t;

    // Read-return tag travelling alongside the RAM access
    typedef struct packed {
        logic vld;
        logic owner_pru;
        logic oob;
    } rd_tag_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [CNT_W-1:0]  r_streak;
    logic              w_scan_gnt;
    logic              w_pru_gnt;
    logic              w_gnt_any;
    logic [ADDR_W-1:0] w_sel_addr;
    logic              w_sel_oob;
    logic              w_sel_read;
    rd_tag_t           r_tag1;
    rd_tag_t           r_tag2;
    logic              r_mem_en;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic              r_err_oob;

    // State register: remembers who owned the previous grant
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state follows this cycle's grant; unused encoding falls back to IDLE
    always_comb begin
        w_state_nxt = ST_IDLE;
        case (r_state)
            ST_IDLE, ST_SCAN, ST_PRU: begin
                if (w_scan_gnt) begin
                    w_state_nxt = ST_SCAN;
                end else if (w_pru_gnt) begin
                    w_state_nxt = ST_PRU;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Grant outputs: scan wins unless the PRU has already waited out a full streak
    always_comb begin
        w_scan_gnt = 1'b0;
        w_pru_gnt  = 1'b0;
        if (i_scan_req && !(i_pru_req && (r_streak == LP_STREAK_MAX))) begin
            w_scan_gnt = 1'b1;
        end else if (i_pru_req) begin
            w_pru_gnt = 1'b1;
        end
    end

    assign w_gnt_any  = w_scan_gnt | w_pru_gnt;
    assign w_sel_addr = w_pru_gnt ? i_pru_addr : i_scan_addr;
    assign w_sel_oob  = (w_sel_addr >= LP_PIX_LIMIT);
    assign w_sel_read = w_scan_gnt | (w_pru_gnt & ~i_pru_we);

    // Streak counts scan grants that overtook a waiting PRU; saturating
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_streak <= '0;
        end else if (!i_pru_req || w_pru_gnt) begin
            r_streak <= '0;
        end else if (w_scan_gnt && (r_streak != LP_STREAK_MAX)) begin
            r_streak <= r_streak + CNT_W'(1);
        end
    end

    // RAM command register; out-of-range accesses are suppressed and flagged
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_mem_en    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_err_oob   <= 1'b0;
        end else begin
            r_mem_en  <= w_gnt_any & ~w_sel_oob;
            r_mem_we  <= w_pru_gnt & i_pru_we & ~w_sel_oob;
            r_err_oob <= w_gnt_any & w_sel_oob;
            if (w_gnt_any) begin
                r_mem_addr  <= w_sel_addr;
                r_mem_wdata <= w_pru_gnt ? i_pru_wdata : '0;
            end
        end
    end

    // Two-stage tag pipeline matching the RAM's one-cycle read latency
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_tag1 <= '0;
            r_tag2 <= '0;
        end else begin
            r_tag1 <= '{vld: w_sel_read, owner_pru: w_pru_gnt, oob: w_sel_oob};
            r_tag2 <= r_tag1;
        end
    end

    assign o_scan_gnt    = w_scan_gnt;
    assign o_pru_gnt     = w_pru_gnt;
    assign o_mem_en      = r_mem_en;
    assign o_mem_we      = r_mem_we;
    assign o_mem_addr    = r_mem_addr;
    assign o_mem_wdata   = r_mem_wdata;
    assign o_err_oob     = r_err_oob;

    // Valid comes only from the tag; out-of-range reads return zero data
    assign o_scan_rvalid = r_tag2.vld & ~r_tag2.owner_pru;
    assign o_pru_rvalid  = r_tag2.vld &  r_tag2.owner_pru;
    assign o_scan_rdata  = (o_scan_rvalid && !r_tag2.oob) ? i_mem_rdata : '0;
    assign o_pru_rdata   = (o_pru_rvalid  && !r_tag2.oob) ? i_mem_rdata : '0;

endmodule

// File: tb/tb_fb_access_arbiter.sv
// Directed bench for fb_access_arbiter with a behavioural single-port RAM.
// Latency: checks grant same cycle, RAM command at t+1, read return at t+2.
// Backpressure: exercises the scan-streak limit with both requesters held.
module tb_fb_access_arbiter;

    logic        clk;
    logic        rst;
    logic        scan_req;
    logic [18:0] scan_addr;
    logic        scan_gnt;
    logic [1:0]  scan_rdata;
    logic        scan_rvalid;
    logic        pru_req;
    logic        pru_we;
    logic [18:0] pru_addr;
    logic [1:0]  pru_wdata;
    logic        pru_gnt;
    logic [1:0]  pru_rdata;
    logic        pru_rvalid;
    logic        mem_en;
    logic        mem_we;
    logic [18:0] mem_addr;
    logic [1:0]  mem_wdata;
    logic [1:0]  mem_rdata;
    logic        err_oob;

    logic        preload;
    logic [1:0]  ram [0:307199];

    int errors = 0;
    int checks = 0;

    fb_access_arbiter #(
        .ADDR_W(19), .DATA_W(2), .PIX_COUNT(307200), .MAX_SCAN_STREAK(8)
    ) dut (
        .i_clk(clk), .i_rst(rst),
        .i_scan_req(scan_req), .i_scan_addr(scan_addr),
        .o_scan_gnt(scan_gnt), .o_scan_rdata(scan_rdata), .o_scan_rvalid(scan_rvalid),
        .i_pru_req(pru_req), .i_pru_we(pru_we), .i_pru_addr(pru_addr), .i_pru_wdata(pru_wdata),
        .o_pru_gnt(pru_gnt), .o_pru_rdata(pru_rdata), .o_pru_rvalid(pru_rvalid),
        .o_mem_en(mem_en), .o_mem_we(mem_we), .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata),
        .i_mem_rdata(mem_rdata), .o_err_oob(err_oob)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single-port RAM: registered read, one-cycle latency; preload fills 0..639 with addr mod 4
    always @(posedge clk) begin
        if (preload) begin
            for (int a = 0; a < 640; a++) ram[a] <= 2'(a % 4);
        end else if (mem_en && (mem_addr < 19'd307200)) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            else        mem_rdata     <= ram[mem_addr];
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        scan_req  = 1'b0;
        scan_addr = '0;
        pru_req   = 1'b0;
        pru_we    = 1'b0;
        pru_addr  = '0;
        pru_wdata = '0;
    endtask

    task automatic test_reset();
        logic [31:0] outs;
        rst       = 1'b1;
        preload   = 1'b1;
        mem_rdata = '0;
        idle_inputs();
        repeat (3) @(posedge clk);
        #1;
        preload = 1'b0;
        rst     = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            outs = {scan_gnt, scan_rdata, scan_rvalid, pru_gnt, pru_rdata, pru_rvalid,
                    mem_en, mem_we, mem_addr, mem_wdata, err_oob};
            checks++;
            if (outs !== 32'h0) begin
                errors++;
                $display("FAIL reset_idle cycle %0d: outputs=%h expected=0", i, outs);
            end
        end
        // Reset lands while a scan read is in flight
        step();
        scan_req  = 1'b1;
        scan_addr = 19'd5;
        @(negedge clk);
        checks++;
        if (scan_gnt !== 1'b1) begin
            errors++;
            $display("FAIL reset_inflight_gnt: scan_gnt=%b expected=1", scan_gnt);
        end
        step();
        scan_req = 1'b0;
        if (mem_en !== 1'b1) begin
            errors++;
            $display("FAIL reset_inflight_en_before: mem_en=%b expected=1", mem_en);
        end
        checks++;
        rst = 1'b1;
        #1;
        checks++;
        if (mem_en !== 1'b0) begin
            errors++;
            $display("FAIL reset_mem_en_drop: mem_en=%b expected=0", mem_en);
        end
        for (int i = 0; i < 8; i++) begin
            if (i == 3) begin
                step();
                rst = 1'b0;
            end
            @(negedge clk);
            checks++;
            if ({scan_rvalid, pru_rvalid} !== 2'b00) begin
                errors++;
                $display("FAIL reset_no_rvalid cycle %0d: rvalid=%b expected=00", i, {scan_rvalid, pru_rvalid});
            end
        end
    endtask

    task automatic test_write_then_read();
        step();
        pru_req   = 1'b1;
        pru_we    = 1'b1;
        pru_addr  = 19'h12C0;
        pru_wdata = 2'b10;
        @(negedge clk);
        checks++;
        if ({scan_gnt, pru_gnt} !== 2'b01) begin
            errors++;
            $display("FAIL wr_gnt: gnt(scan,pru)=%b expected=01", {scan_gnt, pru_gnt});
        end
        step();
        pru_req   = 1'b0;
        pru_we    = 1'b0;
        scan_req  = 1'b1;
        scan_addr = 19'h12C0;
        @(negedge clk);
        checks++;
        if ({mem_en, mem_we, mem_addr, mem_wdata} !== {1'b1, 1'b1, 19'h12C0, 2'b10}) begin
            errors++;
            $display("FAIL wr_mem_cmd: en=%b we=%b addr=%h wdata=%b expected en=1 we=1 addr=12c0 wdata=10",
                     mem_en, mem_we, mem_addr, mem_wdata);
        end
        checks++;
        if (scan_gnt !== 1'b1) begin
            errors++;
            $display("FAIL rd_after_wr_gnt: scan_gnt=%b expected=1", scan_gnt);
        end
        step();
        scan_req = 1'b0;
        @(negedge clk);
        checks++;
        if ({mem_en, mem_we, mem_addr, pru_rvalid} !== {1'b1, 1'b0, 19'h12C0, 1'b0}) begin
            errors++;
            $display("FAIL rd_mem_cmd: en=%b we=%b addr=%h pru_rvalid=%b expected en=1 we=0 addr=12c0 pru_rvalid=0",
                     mem_en, mem_we, mem_addr, pru_rvalid);
        end
        step();
        @(negedge clk);
        checks++;
        if ({scan_rvalid, scan_rdata, pru_rvalid} !== {1'b1, 2'b10, 1'b0}) begin
            errors++;
            $display("FAIL rd_after_wr_data: scan_rvalid=%b scan_rdata=%b pru_rvalid=%b expected 1 10 0",
                     scan_rvalid, scan_rdata, pru_rvalid);
        end
    endtask

    task automatic test_streak_pattern();
        logic [1:0] exp_gnt;
        step();
        scan_req  = 1'b1;
        scan_addr = 19'd10;
        pru_req   = 1'b1;
        pru_we    = 1'b0;
        pru_addr  = 19'd20;
        for (int i = 0; i < 27; i++) begin
            if (i > 0) step();
            @(negedge clk);
            exp_gnt = ((i % 9) == 8) ? 2'b01 : 2'b10;
            checks++;
            if ({scan_gnt, pru_gnt} !== exp_gnt) begin
                errors++;
                $display("FAIL streak_pattern cycle %0d: gnt(scan,pru)=%b expected=%b", i, {scan_gnt, pru_gnt}, exp_gnt);
            end
        end
        step();
        idle_inputs();
    endtask

    task automatic test_streak_restart();
        logic [1:0] exp_gnt;
        step();
        scan_req  = 1'b1;
        scan_addr = 19'd11;
        pru_req   = 1'b1;
        pru_addr  = 19'd21;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) step();
            @(negedge clk);
            checks++;
            if ({scan_gnt, pru_gnt} !== 2'b10) begin
                errors++;
                $display("FAIL restart_pre cycle %0d: gnt(scan,pru)=%b expected=10", i, {scan_gnt, pru_gnt});
            end
        end
        step();
        pru_req = 1'b0;
        @(negedge clk);
        checks++;
        if ({scan_gnt, pru_gnt} !== 2'b10) begin
            errors++;
            $display("FAIL restart_drop: gnt(scan,pru)=%b expected=10", {scan_gnt, pru_gnt});
        end
        step();
        pru_req = 1'b1;
        for (int i = 0; i < 9; i++) begin
            if (i > 0) step();
            @(negedge clk);
            exp_gnt = (i == 8) ? 2'b01 : 2'b10;
            checks++;
            if ({scan_gnt, pru_gnt} !== exp_gnt) begin
                errors++;
                $display("FAIL restart_post cycle %0d: gnt(scan,pru)=%b expected=%b", i, {scan_gnt, pru_gnt}, exp_gnt);
            end
        end
        step();
        idle_inputs();
    endtask

    task automatic test_oob();
        // In-range scan read of addr 3 leaves non-zero data on the RAM output
        step();
        scan_req  = 1'b1;
        scan_addr = 19'd3;
        step();
        scan_req = 1'b0;
        pru_req  = 1'b1;
        pru_we   = 1'b0;
        pru_addr = 19'd307200;
        @(negedge clk);
        checks++;
        if ({scan_gnt, pru_gnt} !== 2'b01) begin
            errors++;
            $display("FAIL oob_rd_gnt: gnt(scan,pru)=%b expected=01", {scan_gnt, pru_gnt});
        end
        step();
        pru_req = 1'b1;
        pru_we  = 1'b1;
        pru_addr  = 19'd400000;
        pru_wdata = 2'b01;
        @(negedge clk);
        checks++;
        if ({mem_en, err_oob, scan_rvalid, scan_rdata} !== {1'b0, 1'b1, 1'b1, 2'b11}) begin
            errors++;
            $display("FAIL oob_rd_cmd: en=%b err_oob=%b scan_rvalid=%b scan_rdata=%b expected 0 1 1 11",
                     mem_en, err_oob, scan_rvalid, scan_rdata);
        end
        checks++;
        if (pru_gnt !== 1'b1) begin
            errors++;
            $display("FAIL oob_wr_gnt: pru_gnt=%b expected=1", pru_gnt);
        end
        step();
        idle_inputs();
        @(negedge clk);
        checks++;
        if ({pru_rvalid, pru_rdata, scan_rvalid} !== {1'b1, 2'b00, 1'b0}) begin
            errors++;
            $display("FAIL oob_rd_return: pru_rvalid=%b pru_rdata=%b scan_rvalid=%b expected 1 00 0",
                     pru_rvalid, pru_rdata, scan_rvalid);
        end
        checks++;
        if ({mem_en, mem_we, err_oob} !== 3'b001) begin
            errors++;
            $display("FAIL oob_wr_cmd: en=%b we=%b err_oob=%b expected 0 0 1", mem_en, mem_we, err_oob);
        end
        step();
        @(negedge clk);
        checks++;
        if ({pru_rvalid, err_oob} !== 2'b00) begin
            errors++;
            $display("FAIL oob_wr_return: pru_rvalid=%b err_oob=%b expected 0 0", pru_rvalid, err_oob);
        end
    endtask

    task automatic test_back_to_back();
        logic [1:0] exp_d;
        step();
        for (int i = 0; i < 642; i++) begin
            if (i < 640) begin
                scan_req  = 1'b1;
                scan_addr = 19'(i);
            end else begin
                scan_req  = 1'b0;
                scan_addr = '0;
            end
            @(negedge clk);
            if (i < 640) begin
                checks++;
                if (scan_gnt !== 1'b1) begin
                    errors++;
                    $display("FAIL b2b_gnt addr %0d: scan_gnt=%b expected=1", i, scan_gnt);
                end
            end
            if (i >= 2) begin
                exp_d = 2'((i - 2) % 4);
                checks++;
                if ({scan_rvalid, scan_rdata} !== {1'b1, exp_d}) begin
                    errors++;
                    $display("FAIL b2b_data addr %0d: rvalid=%b rdata=%b expected 1 %b",
                             i - 2, scan_rvalid, scan_rdata, exp_d);
                end
            end
            step();
        end
        @(negedge clk);
        checks++;
        if (scan_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_tail: scan_rvalid=%b expected=0", scan_rvalid);
        end
    endtask

    initial begin
        test_reset();
        test_write_then_read();
        test_streak_pattern();
        test_streak_restart();
        test_oob();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
